layer_conv_scheduler: RTL and testbench
=======================================

LAYER_CONV_SCHEDULER -- requirements
Module: layer_conv_scheduler

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 104, meaning input featuremap edge length in pixels.
REQ-002 SHALL have parameter NUM_PASSES, default 64, meaning output featuremaps computed sequentially per layer run.
REQ-003 SHALL have parameter ADDR_W, default 14, meaning pixel read-address width, with 2^ADDR_W >= IMG_SIZE*IMG_SIZE.
REQ-004 SHALL have parameter FMAP_W, default 6, meaning featuremap-select width, with 2^FMAP_W >= NUM_PASSES.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-009 SHALL have port stall, input, 1 bit: downstream full; pauses pixel issue.
REQ-010 SHALL have port conv_valid, input, 1 bit: the featuremap block's valid_out.
REQ-011 SHALL have port rd_en, output, 1 bit: input-buffer read strobe.
REQ-012 SHALL have port rd_addr, output, ADDR_W bits: raster pixel address.
REQ-013 SHALL have port feed_valid, output, 1 bit: drives the featuremap block's valid_in, aligned with read data.
REQ-014 SHALL have port fmap_sel, output, FMAP_W bits: current output featuremap index, selecting the weight set.
REQ-015 SHALL have port busy, output, 1 bit: run in progress.
REQ-016 SHALL have ports pass_done and done, output, 1 bit each: single-cycle pulses.
REQ-017 SHALL have port err, output, 1 bit: sticky unexpected-conv_valid flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-019 IDLE: start=1 -> LOAD, pass counter=0, pixel and output counters cleared, err cleared; start in any other state SHALL be ignored.
REQ-020 LOAD: lasts exactly 1 cycle, fmap_sel = pass counter, then -> STREAM.
REQ-021 STREAM: each cycle with stall=0 SHALL assert rd_en with rd_addr=pixel counter, then increment it; with stall=1 rd_en=0 and the counter SHALL hold.
REQ-022 STREAM: when the issued address is IMG_SIZE*IMG_SIZE-1, the next state SHALL be DRAIN.
REQ-023 feed_valid SHALL equal rd_en delayed by exactly 1 cycle, including across the STREAM->DRAIN edge.
REQ-024 Output counter SHALL increment on conv_valid in STREAM or DRAIN; target is (IMG_SIZE-2)*(IMG_SIZE-2).
REQ-025 Reaching target during STREAM SHALL NOT end STREAM; the transition is evaluated in DRAIN only.
REQ-026 DRAIN: when counter equals target, pass_done=1 for 1 cycle; if pass counter = NUM_PASSES-1 -> DONE, else pass counter+1 and -> LOAD.
REQ-027 DONE: done=1 for 1 cycle, then -> IDLE.
REQ-028 busy SHALL be 1 in LOAD, STREAM, DRAIN and DONE.
REQ-029 conv_valid in IDLE, LOAD or DONE, or beyond target, SHALL set err, which holds until the next accepted start.
REQ-030 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, deasserting rd_en, feed_valid and busy, with no pass_done or done pulse; fmap_sel holds.
REQ-031 abort and start in the same IDLE cycle: abort SHALL win and the block stays IDLE.

Reset
REQ-032 Rst=0 SHALL asynchronously force IDLE, all counters 0, and rd_en, rd_addr, feed_valid, fmap_sel, busy, pass_done, done and err to 0.
REQ-033 Reset mid-run SHALL discard progress; after release only a new start begins a run.

Verification (IMG_SIZE=4, NUM_PASSES=2)
REQ-034 Start pulse, no stall, conv_valid 4 times in DRAIN -> LOAD (fmap_sel=0), rd_addr 0..15 on 16 consecutive cycles, feed_valid lagging 1 cycle, pass_done, then fmap_sel=1, repeat, then done pulse and busy=0.
REQ-035 stall=1 for 3 cycles at rd_addr=5 -> address 5 is issued once, rd_en is 0 for 3 cycles, and the total issue stays at 16 addresses.
REQ-036 All 4 conv_valid pulses during STREAM -> STREAM completes all 16 addresses, then pass_done on the first DRAIN cycle.
REQ-037 conv_valid in IDLE -> err=1; next start -> err=0.
REQ-038 abort at rd_addr=9 of pass 1 -> IDLE next cycle, busy=0, no done; new start restarts at fmap_sel=0, rd_addr=0.
REQ-039 Rst=0 asserted in DRAIN -> all outputs 0 immediately, independent of Clk.

Source files
------------

// File: rtl/layer_conv_scheduler.sv
// Layer convolution scheduler: walks every output featuremap of a layer in turn.
// Each pass raster-reads the input featuremap, then waits until the featuremap
// block has produced all (IMG_SIZE-2)^2 outputs before moving to the next pass.
module layer_conv_scheduler #(
  parameter int IMG_SIZE   = 104,
  parameter int NUM_PASSES = 64,
  parameter int ADDR_W     = 14,
  parameter int FMAP_W     = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic              conv_valid,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              feed_valid,
  output logic [FMAP_W-1:0] fmap_sel,
  output logic              busy,
  output logic              pass_done,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_SIZE*IMG_SIZE - 1);
  localparam logic [ADDR_W-1:0] TARGET    = ADDR_W'((IMG_SIZE-2)*(IMG_SIZE-2));
  localparam logic [FMAP_W-1:0] LAST_PASS = FMAP_W'(NUM_PASSES - 1);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pix_cnt, out_cnt;
  logic [FMAP_W-1:0] pass_cnt;
  logic              last_pix, out_full, conv_ok, run_go;

  // Abort also suppresses the read of its own cycle, so feed_valid never
  // reports data for a run that has already been cancelled.
  assign rd_en     = (state == STREAM) && !stall && !abort;
  assign rd_addr   = pix_cnt;
  assign fmap_sel  = pass_cnt;
  assign busy      = (state != IDLE);
  assign last_pix  = rd_en && (pix_cnt == LAST_PIX);
  assign out_full  = (out_cnt == TARGET);
  assign pass_done = (state == DRAIN) && out_full && !abort;
  assign done      = (state == DONE) && !abort;
  assign conv_ok   = ((state == STREAM) || (state == DRAIN)) && !out_full;
  assign run_go    = (state == IDLE) && start && !abort;

  // Next-state: abort beats everything, including start in IDLE.
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    state_nxt = STREAM;
        STREAM:  if (last_pix) state_nxt = DRAIN;
        DRAIN:   if (out_full) state_nxt = (pass_cnt == LAST_PASS) ? DONE : LOAD;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and the one-cycle read-data alignment flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      feed_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      feed_valid <= rd_en;
    end
  end

  // Pixel counter: advances per issued read, wraps after the last pixel.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                  pix_cnt <= '0;
    else if (run_go || abort)  pix_cnt <= '0;
    else if (rd_en)            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
  end

  // Output counter: restarts every pass, counts only in-window conv results.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                          out_cnt <= '0;
    else if (run_go || state == LOAD)  out_cnt <= '0;
    else if (conv_valid && conv_ok)    out_cnt <= out_cnt + 1'b1;
  end

  // Pass counter: held on abort so fmap_sel still shows the cancelled pass.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                   pass_cnt <= '0;
    else if (run_go)                            pass_cnt <= '0;
    else if (pass_done && pass_cnt != LAST_PASS) pass_cnt <= pass_cnt + 1'b1;
  end

  // Sticky error: a conv result nobody asked for; cleared by an accepted start.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                         err <= 1'b0;
    else if (run_go)                  err <= 1'b0;
    else if (conv_valid && !conv_ok)  err <= 1'b1;
  end

endmodule

// File: tb/tb_layer_conv_scheduler.sv
// Directed bench for layer_conv_scheduler (4x4 image, 2 passes).
// Stimulus queues expected read/pass_done/done events; a negedge monitor
// pops and compares them whenever the DUT presents one.
module tb_layer_conv_scheduler;
  localparam int IMG = 4, NP = 2, AW = 4, FW = 1, NPIX = IMG*IMG;
  localparam int EV_RD = 0, EV_PD = 1, EV_DN = 2;

  logic Clk = 1'b0, Rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, stall = 1'b0, conv_valid = 1'b0;
  logic rd_en, feed_valid, busy, pass_done, done, err;
  logic [AW-1:0] rd_addr;
  logic [FW-1:0] fmap_sel;

  int n_cmp = 0, n_bad = 0;
  typedef struct { int kind; int addr; int fmap; } evt_t;
  evt_t sb[$];
  logic prev_rd = 1'b0;

  always #5 Clk = ~Clk;

  layer_conv_scheduler #(.IMG_SIZE(IMG), .NUM_PASSES(NP), .ADDR_W(AW), .FMAP_W(FW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort), .stall(stall),
    .conv_valid(conv_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .feed_valid(feed_valid), .fmap_sel(fmap_sel), .busy(busy),
    .pass_done(pass_done), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_evt(input int kind, input int addr, input int f);
    evt_t e;
    e.kind = kind; e.addr = addr; e.fmap = f;
    sb.push_back(e);
  endtask

  task automatic push_pass(input int f, input int nrd, input bit pd);
    for (int a = 0; a < nrd; a++) push_evt(EV_RD, a, f);
    if (pd) push_evt(EV_PD, 0, f);
  endtask

  task automatic take(input int kind, input int addr, input int f);
    evt_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d addr=%0d fmap=%0d, expected none (t=%0t)", kind, addr, f, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.addr != addr || e.fmap != f) begin
        n_bad++;
        $display("FAIL event: got kind=%0d addr=%0d fmap=%0d, expected kind=%0d addr=%0d fmap=%0d (t=%0t)",
                 kind, addr, f, e.kind, e.addr, e.fmap, $time);
      end
    end
  endtask

  // Monitor: event scoreboard plus feed_valid == rd_en of the previous cycle.
  initial forever begin
    @(negedge Clk);
    if (Rst) begin
      chk("feed_valid_lag", feed_valid, prev_rd);
      if (rd_en)     take(EV_RD, int'(rd_addr), int'(fmap_sel));
      if (pass_done) take(EV_PD, 0, int'(fmap_sel));
      if (done)      take(EV_DN, 0, 0);
      prev_rd = rd_en;
    end else prev_rd = 1'b0;
  end

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic do_start();
    cyc(); start = 1'b1; cyc(); start = 1'b0;
  endtask

  // Entered in LOAD; leaves after the DRAIN exit edge unless stop_in_drain.
  task automatic run_pass(input int stall_at, input bit conv_stream, input bit load_conv, input bit stop_in_drain);
    conv_valid = load_conv;
    cyc();
    conv_valid = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      if (k == stall_at) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_rd_en", rd_en, 0);
          chk("stall_rd_addr", rd_addr, k);
          cyc();
        end
        stall = 1'b0;
      end
      conv_valid = (conv_stream && k >= 2 && k < 6);
      cyc();
    end
    conv_valid = 1'b0;
    #1;
    chk("drain_first_pass_done", pass_done, conv_stream);
    if (!stop_in_drain) begin
      if (!conv_stream) begin
        for (int c = 0; c < 4; c++) begin conv_valid = 1'b1; cyc(); end
        conv_valid = 1'b0;
      end
      cyc();
    end
  endtask

  task automatic full_run();
    push_pass(0, NPIX, 1); push_pass(1, NPIX, 1); push_evt(EV_DN, 0, 0);
    do_start();
    chk("load_fmap0", fmap_sel, 0);
    chk("load_busy", busy, 1);
    run_pass(-1, 0, 0, 0);
    chk("load_fmap1", fmap_sel, 1);
    run_pass(-1, 0, 0, 0);
    cyc();
    chk("end_busy", busy, 0);
    chk("end_queue_empty", sb.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_rd_en", rd_en, 0);       chk("rst_rd_addr", rd_addr, 0);
    chk("rst_feed_valid", feed_valid, 0); chk("rst_fmap_sel", fmap_sel, 0);
    chk("rst_busy", busy, 0);         chk("rst_pass_done", pass_done, 0);
    chk("rst_done", done, 0);         chk("rst_err", err, 0);
    cyc(); Rst = 1'b1; cyc(); cyc();

    // Plain two-pass run.
    full_run();

    // Stall at address 5 in pass 0; all conv results arrive during STREAM in pass 1.
    push_pass(0, NPIX, 1); push_pass(1, NPIX, 1); push_evt(EV_DN, 0, 0);
    do_start();
    run_pass(5, 0, 0, 0);
    run_pass(-1, 1, 0, 0);
    cyc();
    chk("stall_run_busy", busy, 0);
    chk("stall_run_queue_empty", sb.size(), 0);

    // Unexpected conv_valid in IDLE, cleared by the next start.
    conv_valid = 1'b1; cyc(); conv_valid = 1'b0; #1;
    chk("err_set_idle", err, 1);
    push_pass(0, NPIX, 1); push_pass(1, 10, 0);
    do_start();
    chk("err_clear_start", err, 0);
    run_pass(-1, 0, 0, 0);

    // Abort right after address 9 of pass 1.
    cyc();
    for (int k = 0; k < 10; k++) cyc();
    abort = 1'b1; cyc(); abort = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_feed_valid", feed_valid, 0);
    chk("abort_fmap_hold", fmap_sel, 1);
    repeat (3) cyc();
    chk("abort_still_idle", busy, 0);
    chk("abort_queue_empty", sb.size(), 0);
    full_run();

    // Abort and start together in IDLE: stays idle.
    abort = 1'b1; start = 1'b1; cyc(); abort = 1'b0; start = 1'b0; #1;
    chk("abort_beats_start", busy, 0);
    repeat (2) cyc();

    // Reset asserted mid-cycle in DRAIN of pass 1 with err set.
    push_pass(0, NPIX, 1); push_pass(1, NPIX, 0);
    do_start();
    run_pass(-1, 0, 0, 0);
    run_pass(-1, 0, 1, 1);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_err", err, 1);
    chk("pre_rst_fmap", fmap_sel, 1);
    #1 Rst = 1'b0; #1;
    chk("async_rd_en", rd_en, 0);       chk("async_rd_addr", rd_addr, 0);
    chk("async_feed_valid", feed_valid, 0); chk("async_fmap_sel", fmap_sel, 0);
    chk("async_busy", busy, 0);         chk("async_pass_done", pass_done, 0);
    chk("async_done", done, 0);         chk("async_err", err, 0);
    cyc(); cyc(); Rst = 1'b1;
    repeat (3) cyc();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_queue_empty", sb.size(), 0);
    full_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
